// File: rtl/wb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter_if
//   Wishbone point-to-point bundle used on each side of the master arbiter.
//   The same bundle describes a master port (M0/M1) and the shared slave bus.
//
//   Signals
//     adr       address
//     cyc       cycle request
//     byte_stb  byte enables
//     we        write enable
//     rd        read enable
//     stb       strobe
//     wr_dat    write data
//     rd_dat    read data (slave -> master)
//     ack       acknowledge (slave -> master)
//
//   Modports
//     master  : drives the request side, receives rd_dat/ack
//     slave   : receives the request side, drives rd_dat/ack
// ---------------------------------------------------------------------------
interface wb_master_arbiter_if #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32
);
  logic [ADDRWIDTH-1:0] adr;
  logic                 cyc;
  logic [3:0]           byte_stb;
  logic                 we;
  logic                 rd;
  logic                 stb;
  logic [DATAWIDTH-1:0] wr_dat;
  logic [DATAWIDTH-1:0] rd_dat;
  logic                 ack;

  modport master (
    output adr, cyc, byte_stb, we, rd, stb, wr_dat,
    input  rd_dat, ack
  );

  modport slave (
    input  adr, cyc, byte_stb, we, rd, stb, wr_dat,
    output rd_dat, ack
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
//   Shares one Wishbone slave bus between M0 (AHB-to-FPGA bridge) and M1
//   (fabric sequencer/DMA). Round-robin arbitration in IDLE; a grant is held
//   for the whole CYC transaction. An optional bus-timeout watchdog ends
//   cycles that no slave acknowledges.
//
//   Optional feature macro: WB_ARB_TIMEOUT_EN
//     defined   : watchdog counter, TOUT state and timeout pulse are built
//     undefined : no watchdog; an unacknowledged cycle holds the grant
//
//   Ports
//     clk      bus clock (WBs_CLK_i)
//     rst_n    asynchronous active-low reset (WBs_RST_i)
//     m0       master 0 port        (slave modport: arbiter answers M0)
//     m1       master 1 port        (slave modport: arbiter answers M1)
//     wbs      shared slave bus     (master modport: arbiter drives WBs_*)
//     grant    one-hot current grant {M1,M0}
//     timeout  one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_master_arbiter #(
  parameter int                   ADDRWIDTH          = 17,
  parameter int                   DATAWIDTH          = 32,
  parameter int                   TIMEOUT_CYCLES     = 255,
  parameter int                   TIMEOUT_CNTR_WIDTH = 8,
  parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  wb_master_arbiter_if.slave         m0,
  wb_master_arbiter_if.slave         m1,
  wb_master_arbiter_if.master        wbs,
  output logic [1:0]                 grant,
  output logic                       timeout
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, TOUT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
`endif

  state_t state_reg, state_next;
  // Last-served master: 0 = M0, 1 = M1. Reset to M1 so M0 wins the first tie.
  logic   last_reg, last_next;

  logic   sel0, sel1;      // granted master is still holding CYC
  logic   in_tout;         // watchdog termination cycle
  logic   wd_fire;         // watchdog limit reached without ACK this cycle
  logic   bus_cyc, bus_stb;

  // A granted master that has dropped CYC already sees an all-zero slave bus
  // in its final grant cycle, and a late slave ACK is not passed back.
  assign sel0 = (state_reg == GNT0) && m0.cyc;
  assign sel1 = (state_reg == GNT1) && m1.cyc;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_LIMIT =
    TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_reg, cnt_next;

  assign in_tout = (state_reg == TOUT);

  // Counts stalled strobes. Any cycle that is not a stalled strobe (ACK seen,
  // STB low, or no granted cycle on the bus) clears it. ACK on the limit
  // cycle wins because the stall term already excludes it.
  always_comb begin
    cnt_next = '0;
    wd_fire  = 1'b0;
    if (bus_cyc && bus_stb && !wbs.ack) begin
      if (cnt_reg == CNT_LIMIT) begin
        wd_fire = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign in_tout = 1'b0;
  assign wd_fire = 1'b0;
`endif

  // State and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic. The pointer is written whenever a grant state is
  // entered, so it always names the master that currently owns the bus.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_reg)) begin
          state_next = GNT0;
          last_next  = 1'b0;
        end else if (m1.cyc) begin
          state_next = GNT1;
          last_next  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0.cyc) begin
          state_next = IDLE;
        end else if (wd_fire) begin
`ifdef WB_ARB_TIMEOUT_EN
          state_next = TOUT;
`endif
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          state_next = IDLE;
        end else if (wd_fire) begin
`ifdef WB_ARB_TIMEOUT_EN
          state_next = TOUT;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      TOUT: begin
        // Return to the same master if it is still asking for the bus.
        if (last_reg ? m1.cyc : m0.cyc) begin
          state_next = last_reg ? GNT1 : GNT0;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Slave-side mux: zero whenever nobody is actively granted (IDLE, TOUT,
  // or the owner has just dropped CYC).
  always_comb begin
    bus_cyc      = 1'b0;
    bus_stb      = 1'b0;
    wbs.adr      = '0;
    wbs.byte_stb = '0;
    wbs.we       = 1'b0;
    wbs.rd       = 1'b0;
    wbs.wr_dat   = '0;
    if (sel0) begin
      bus_cyc      = 1'b1;
      bus_stb      = m0.stb;
      wbs.adr      = m0.adr;
      wbs.byte_stb = m0.byte_stb;
      wbs.we       = m0.we;
      wbs.rd       = m0.rd;
      wbs.wr_dat   = m0.wr_dat;
    end else if (sel1) begin
      bus_cyc      = 1'b1;
      bus_stb      = m1.stb;
      wbs.adr      = m1.adr;
      wbs.byte_stb = m1.byte_stb;
      wbs.we       = m1.we;
      wbs.rd       = m1.rd;
      wbs.wr_dat   = m1.wr_dat;
    end
  end

  assign wbs.cyc = bus_cyc;
  assign wbs.stb = bus_stb;

  // Master return path: slave response to the owner only; during TOUT the
  // owner (named by the pointer) receives a synthetic ACK and default data.
  always_comb begin
    m0.ack    = 1'b0;
    m0.rd_dat = '0;
    m1.ack    = 1'b0;
    m1.rd_dat = '0;
    if (sel0) begin
      m0.ack    = wbs.ack;
      m0.rd_dat = wbs.rd_dat;
    end else if (sel1) begin
      m1.ack    = wbs.ack;
      m1.rd_dat = wbs.rd_dat;
    end else if (in_tout) begin
      if (last_reg) begin
        m1.ack    = 1'b1;
        m1.rd_dat = DEFAULT_READ_VALUE;
      end else begin
        m0.ack    = 1'b1;
        m0.rd_dat = DEFAULT_READ_VALUE;
      end
    end
  end

  always_comb begin
    grant = 2'b00;
    case (state_reg)
      GNT0:    grant = 2'b01;
      GNT1:    grant = 2'b10;
      IDLE:    grant = 2'b00;
      default: grant = last_reg ? 2'b10 : 2'b01;  // TOUT keeps the owner
    endcase
  end

  assign timeout = in_tout;

endmodule

// File: tb/tb_wb_master_arbiter.sv
`timescale 1ns/1ps
module tb_wb_master_arbiter;
  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int TOW = 4;
  localparam logic [DW-1:0] DEF_RD = 32'hBADFABAC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant;
  logic timeout;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: who was served last (0 = M0, 1 = M1).
  int last_served = 1;

  wb_master_arbiter_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) m0_bus ();
  wb_master_arbiter_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) m1_bus ();
  wb_master_arbiter_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) wbs_bus ();

  wb_master_arbiter #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO),
    .TIMEOUT_CNTR_WIDTH(TOW), .DEFAULT_READ_VALUE(DEF_RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_bus), .m1(m1_bus), .wbs(wbs_bus),
    .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run did not finish, expected finish before 500us");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  // Round-robin rule: with both requesting, the one not served last wins.
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return (last_served == 0) ? 1 : 0;
    return r0 ? 0 : 1;
  endfunction

  function automatic logic mack(input int m);
    return (m == 0) ? m0_bus.ack : m1_bus.ack;
  endfunction

  function automatic logic [DW-1:0] mrd(input int m);
    return (m == 0) ? m0_bus.rd_dat : m1_bus.rd_dat;
  endfunction

  task automatic drive_master(input int m, input bit cyc, input bit stb, input bit we,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.rd = stb & ~we;
      m0_bus.adr = a; m0_bus.wr_dat = wd; m0_bus.byte_stb = stb ? 4'hF : 4'h0;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.rd = stb & ~we;
      m1_bus.adr = a; m1_bus.wr_dat = wd; m1_bus.byte_stb = stb ? 4'hF : 4'h0;
    end
  endtask

  // Serve the currently granted master m for a number of beats with random
  // slave wait states, then drop its CYC. Entered just after a negedge.
  task automatic serve(input int m, input int beats);
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rdv;
    bit we;
    int w;
    for (int b = 0; b < beats; b++) begin
      a = AW'($urandom); wd = $urandom; rdv = $urandom;
      we = 1'($urandom_range(0, 1)); w = $urandom_range(0, 3);
      drive_master(m, 1'b1, 1'b1, we, a, wd);
      wbs_bus.ack = 1'b0; wbs_bus.rd_dat = rdv;
      for (int i = 0; i < w; i++) begin
        #1;
        vectors++;
        if (wbs_bus.cyc !== 1'b1 || wbs_bus.adr !== a || wbs_bus.wr_dat !== wd || wbs_bus.we !== we) begin
          errors++;
          $display("FAIL bus_mux_m%0d: cyc=%b adr=%h wdat=%h we=%b, expected cyc=1 adr=%h wdat=%h we=%b",
                   m, wbs_bus.cyc, wbs_bus.adr, wbs_bus.wr_dat, wbs_bus.we, a, wd, we);
        end
        vectors++;
        if (mack(m) !== 1'b0) begin
          errors++; $display("FAIL wait_ack_m%0d: ack=%b expected 0", m, mack(m));
        end
        tick();
      end
      wbs_bus.ack = 1'b1;
      #1;
      vectors++;
      if (grant !== onehot(m)) begin
        errors++; $display("FAIL beat_grant_m%0d: grant=%b expected %b", m, grant, onehot(m));
      end
      vectors++;
      if (mack(m) !== 1'b1 || mrd(m) !== rdv) begin
        errors++; $display("FAIL beat_resp_m%0d: ack=%b rd=%h expected ack=1 rd=%h", m, mack(m), mrd(m), rdv);
      end
      vectors++;
      if (mack(1 - m) !== 1'b0 || mrd(1 - m) !== '0) begin
        errors++; $display("FAIL other_resp_m%0d: ack=%b rd=%h expected ack=0 rd=0",
                           1 - m, mack(1 - m), mrd(1 - m));
      end
      tick();
      wbs_bus.ack = 1'b0;
    end
    drive_master(m, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    vectors++;
    if (wbs_bus.cyc !== 1'b0 || wbs_bus.stb !== 1'b0 || wbs_bus.adr !== '0) begin
      errors++; $display("FAIL release_bus_m%0d: cyc=%b stb=%b adr=%h expected all 0",
                         m, wbs_bus.cyc, wbs_bus.stb, wbs_bus.adr);
    end
    $display("txn m%0d beats=%0d last_adr=%h", m, beats, a);
  endtask

  // One arbitration round starting from an idle bus. With late set, the
  // master that did not request joins while the first one is being served.
  task automatic round(input bit r0, input bit r1, input int b0, input int b1, input bit late);
    int first, second;
    bit other_req;
    tick();
    if (r0) drive_master(0, 1'b1, 1'b1, 1'b0, AW'($urandom), $urandom);
    if (r1) drive_master(1, 1'b1, 1'b1, 1'b0, AW'($urandom), $urandom);
    #1;
    vectors++;
    if (grant !== 2'b00 || wbs_bus.cyc !== 1'b0) begin
      errors++; $display("FAIL req_latency: grant=%b cyc=%b expected 00/0", grant, wbs_bus.cyc);
    end
    tick();
    first = pick(r0, r1);
    last_served = first;
    #1;
    vectors++;
    if (grant !== onehot(first)) begin
      errors++; $display("FAIL first_grant: grant=%b expected %b", grant, onehot(first));
    end
    other_req = (first == 0) ? r1 : r0;
    if (late && !other_req) begin
      drive_master(1 - first, 1'b1, 1'b1, 1'b0, AW'($urandom), $urandom);
      other_req = 1'b1;
    end
    serve(first, (first == 0) ? b0 : b1);
    tick(); #1;
    vectors++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL idle_gap: grant=%b expected 00", grant);
    end
    if (other_req) begin
      second = 1 - first;
      tick();
      last_served = second;
      #1;
      vectors++;
      if (grant !== onehot(second)) begin
        errors++; $display("FAIL second_grant: grant=%b expected %b", grant, onehot(second));
      end
      serve(second, (second == 0) ? b0 : b1);
      tick(); #1;
      vectors++;
      if (grant !== 2'b00) begin
        errors++; $display("FAIL idle_after: grant=%b expected 00", grant);
      end
    end
  endtask

  task automatic test_reset();
    drive_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
    wbs_bus.ack = 1'b0; wbs_bus.rd_dat = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    last_served = 1;
    #1;
    vectors++;
    if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: grant=%b expected 00", grant); end
    vectors++;
    if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack: m0=%b m1=%b expected 0/0", m0_bus.ack, m1_bus.ack);
    end
    vectors++;
    if (wbs_bus.cyc !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset_bus: cyc=%b timeout=%b expected 0/0", wbs_bus.cyc, timeout);
    end
  endtask

  task automatic test_single_read();
    tick();
    drive_master(0, 1'b1, 1'b1, 1'b0, 17'h00000, '0);
    wbs_bus.rd_dat = 32'h12345678; wbs_bus.ack = 1'b0;
    #1;
    vectors++;
    if (wbs_bus.cyc !== 1'b0) begin errors++; $display("FAIL read_early_cyc: cyc=%b expected 0", wbs_bus.cyc); end
    tick();
    last_served = 0;
    #1;
    vectors++;
    if (wbs_bus.cyc !== 1'b1 || grant !== 2'b01 || wbs_bus.adr !== 17'h00000) begin
      errors++; $display("FAIL read_grant: cyc=%b grant=%b adr=%h expected 1/01/00000",
                         wbs_bus.cyc, grant, wbs_bus.adr);
    end
    wbs_bus.ack = 1'b1;
    #1;
    vectors++;
    if (m0_bus.ack !== 1'b1 || m0_bus.rd_dat !== 32'h12345678) begin
      errors++; $display("FAIL read_data: ack=%b rd=%h expected 1/12345678", m0_bus.ack, m0_bus.rd_dat);
    end
    tick();
    wbs_bus.ack = 1'b0;
    drive_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    vectors++;
    if (m0_bus.ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: ack=%b expected 0", m0_bus.ack); end
    tick(); #1;
    vectors++;
    if (grant !== 2'b00) begin errors++; $display("FAIL read_release: grant=%b expected 00", grant); end
    $display("txn m0 read adr=00000 data=12345678");
  endtask

  task automatic test_contention();
    for (int r = 0; r < 3; r++) round(1'b1, 1'b1, 1, 1, 1'b0);
  endtask

  task automatic test_hold();
    round(1'b0, 1'b1, 1, 3, 1'b1);
  endtask

  task automatic test_random();
    bit r0, r1;
    for (int r = 0; r < 16; r++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      round(r0, r1, $urandom_range(1, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [DW-1:0] rdv;
    tick();
    drive_master(0, 1'b1, 1'b1, 1'b0, 17'h02000, '0);
    wbs_bus.ack = 1'b0; wbs_bus.rd_dat = 32'h55AA55AA;
    tick();
    last_served = 0;
    for (int k = 1; k <= TO; k++) begin
      #1;
      vectors++;
      if (wbs_bus.cyc !== 1'b1 || timeout !== 1'b0 || m0_bus.ack !== 1'b0) begin
        errors++; $display("FAIL tout_wait_%0d: cyc=%b timeout=%b ack=%b expected 1/0/0",
                           k, wbs_bus.cyc, timeout, m0_bus.ack);
      end
      tick();
    end
    #1;
    vectors++;
    if (timeout !== 1'b1 || m0_bus.ack !== 1'b1 || m0_bus.rd_dat !== DEF_RD) begin
      errors++; $display("FAIL tout_fire: timeout=%b ack=%b rd=%h expected 1/1/%h",
                         timeout, m0_bus.ack, m0_bus.rd_dat, DEF_RD);
    end
    vectors++;
    if (wbs_bus.cyc !== 1'b0 || grant !== 2'b01) begin
      errors++; $display("FAIL tout_bus: cyc=%b grant=%b expected 0/01", wbs_bus.cyc, grant);
    end
    drive_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick(); #1;
    vectors++;
    if (timeout !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL tout_after: timeout=%b grant=%b expected 0/00", timeout, grant);
    end
    $display("txn m0 read adr=02000 timed out");
    // Race: slave ACK on the limit cycle wins.
    rdv = $urandom;
    tick();
    drive_master(1, 1'b1, 1'b1, 1'b0, AW'($urandom), '0);
    tick();
    last_served = 1;
    for (int k = 1; k < TO; k++) tick();
    wbs_bus.ack = 1'b1; wbs_bus.rd_dat = rdv;
    #1;
    vectors++;
    if (m1_bus.ack !== 1'b1 || m1_bus.rd_dat !== rdv || timeout !== 1'b0) begin
      errors++; $display("FAIL race_ack: ack=%b rd=%h timeout=%b expected 1/%h/0",
                         m1_bus.ack, m1_bus.rd_dat, timeout, rdv);
    end
    tick();
    wbs_bus.ack = 1'b0;
    #1;
    vectors++;
    if (timeout !== 1'b0 || grant !== 2'b10) begin
      errors++; $display("FAIL race_after: timeout=%b grant=%b expected 0/10", timeout, grant);
    end
    drive_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    $display("txn m1 read ack on limit cycle");
  endtask
`else
  task automatic test_timeout();
    tick();
    drive_master(0, 1'b1, 1'b1, 1'b0, 17'h02000, '0);
    wbs_bus.ack = 1'b0;
    tick();
    last_served = 0;
    repeat (3 * TO) tick();
    #1;
    vectors++;
    if (grant !== 2'b01 || wbs_bus.cyc !== 1'b1 || timeout !== 1'b0 || m0_bus.ack !== 1'b0) begin
      errors++; $display("FAIL no_tout_hold: grant=%b cyc=%b timeout=%b ack=%b expected 01/1/0/0",
                         grant, wbs_bus.cyc, timeout, m0_bus.ack);
    end
    drive_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    $display("txn m0 read adr=02000 held without ack");
  endtask
`endif

  task automatic test_async_reset();
    tick();
    drive_master(1, 1'b1, 1'b1, 1'b1, AW'($urandom), $urandom);
    tick();
    last_served = 1;
    wbs_bus.ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (wbs_bus.cyc !== 1'b0 || m1_bus.ack !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL async_reset: cyc=%b ack=%b grant=%b expected 0/0/00",
                         wbs_bus.cyc, m1_bus.ack, grant);
    end
    wbs_bus.ack = 1'b0;
    drive_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    rst_n = 1'b1;
    last_served = 1;
    $display("txn m1 write aborted by reset");
    round(1'b1, 1'b1, 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_hold();
    test_timeout();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
